// File: rtl/branch_pkg.sv
// Shared encodings for the branch control sequencer: FSM states, PC
// function codes, opcode patterns, condition codes and the control-word
// layout, plus the instruction classifier used by the sequencer.
package branch_pkg;

    localparam int CW_WIDTH = 33;

    // FSM state encodings (also the value of the next_state field)
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_EVAL   = 2'b01;
    localparam logic [1:0] ST_BRANCH = 2'b10;
    localparam logic [1:0] ST_LINK   = 2'b11;

    // PC function select
    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_INC4 = 2'b01;
    localparam logic [1:0] PC_REL  = 2'b10;
    localparam logic [1:0] PC_BUS  = 2'b11;

    localparam logic [4:0] ALU_PASS_A = 5'b00100;

    // Opcode patterns
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [5:0]  OP_BL    = 6'b100101;
    localparam logic [21:0] OP_BR    = 22'b1101011000011111000000;

    // ARM condition codes
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    typedef enum logic [2:0] {
        K_NONE, K_CBZ, K_CBNZ, K_BCOND, K_B, K_BL, K_BR
    } kind_e;

    // Control word, MSB first
    typedef struct packed {
        logic       alu_en;
        logic       alu_b_sel;
        logic [4:0] alu_fs;
        logic       rf_b_en;
        logic [4:0] sel_a;
        logic [4:0] sel_b;
        logic [4:0] rf_addr;
        logic       rf_write;
        logic       ram_en;
        logic       ram_write;
        logic       pc_en;
        logic [1:0] pc_fs;
        logic       pc_in_sel;
        logic       status_load;
        logic [1:0] next_state;
    } cw_t;

    // Classify an instruction word; BL is only recognised when enabled.
    function automatic kind_e decode(input logic [31:0] instr, input logic enable_bl);
        kind_e k;
        k = K_NONE;
        if (instr[31:24] == OP_CBZ)                        k = K_CBZ;
        else if (instr[31:24] == OP_CBNZ)                  k = K_CBNZ;
        else if (instr[31:24] == OP_BCOND && !instr[4])    k = K_BCOND;
        else if (instr[31:26] == OP_B)                     k = K_B;
        else if (instr[31:26] == OP_BL && enable_bl)       k = K_BL;
        else if (instr[31:10] == OP_BR)                    k = K_BR;
        return k;
    endfunction

endpackage

// File: rtl/cond_evaluator.sv
// Evaluates an ARM condition code against the registered {V,C,N,Z} flags.
module cond_evaluator
    import branch_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,   // {V, C, N, Z}
    output logic       taken_o
);

    logic z, n, c, v;

    assign z = flags_i[0];
    assign n = flags_i[1];
    assign c = flags_i[2];
    assign v = flags_i[3];

    // Map each condition code to its flag expression; NV behaves as AL.
    always_comb begin
        taken_o = 1'b1;
        case (cond_i)
            COND_EQ: taken_o = z;
            COND_NE: taken_o = !z;
            COND_CS: taken_o = c;
            COND_CC: taken_o = !c;
            COND_MI: taken_o = n;
            COND_PL: taken_o = !n;
            COND_VS: taken_o = v;
            COND_VC: taken_o = !v;
            COND_HI: taken_o = c && !z;
            COND_LS: taken_o = !(c && !z);
            COND_GE: taken_o = (n == v);
            COND_LT: taken_o = (n != v);
            COND_GT: taken_o = !z && (n == v);
            COND_LE: taken_o = !(!z && (n == v));
            COND_AL: taken_o = 1'b1;
            COND_NV: taken_o = 1'b1;
            default: taken_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_sequencer.sv
// Multi-cycle branch control sequencer: accepts CBZ/CBNZ/B/BL/B.cond/BR,
// steps through EVAL/LINK/BRANCH and emits one datapath control word per
// cycle together with the scaled branch offset.
module branch_sequencer
    import branch_pkg::*;
#(
    parameter int         DATA_WIDTH = 64,
    parameter logic [4:0] LINK_REG   = 5'd30,
    parameter logic [4:0] ZERO_REG   = 5'd31,
    parameter logic       ENABLE_BL  = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           instruction,
    input  logic                  instr_valid,
    input  logic [4:0]            status,
    output logic [CW_WIDTH-1:0]   controlword,
    output logic [DATA_WIDTH-1:0] constant,
    output logic                  busy,
    output logic                  done,
    output logic                  branch_taken,
    output logic                  illegal
);

    logic [1:0]  state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        illegal_q, illegal_d;
    kind_e       kind_in, kind_q;
    logic        cond_taken;
    logic        taken;
    cw_t         cw;
    logic        status_unused;

    assign kind_in       = decode(instruction, ENABLE_BL);
    assign kind_q        = decode(instr_q, ENABLE_BL);
    assign status_unused = status[4];

    cond_evaluator u_cond (
        .cond_i  (instr_q[3:0]),
        .flags_i (status[3:0]),
        .taken_o (cond_taken)
    );

    // Next-state logic: accept in IDLE, then walk EVAL/LINK towards BRANCH.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        illegal_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    case (kind_in)
                        K_CBZ, K_CBNZ: begin
                            state_d = ST_EVAL;
                            instr_d = instruction;
                        end
                        K_BL: begin
                            state_d = ST_LINK;
                            instr_d = instruction;
                        end
                        K_B, K_BCOND, K_BR: begin
                            state_d = ST_BRANCH;
                            instr_d = instruction;
                        end
                        default: illegal_d = 1'b1;
                    endcase
                end
            end
            ST_EVAL, ST_LINK: state_d = ST_BRANCH;
            default:          state_d = ST_IDLE;
        endcase
    end

    // State, latched instruction and illegal pulse registers.
    always_ff @(posedge clock) begin
        // NOTE: registers update with <= so every flop samples pre-edge values.
        if (reset) begin
            state_q   <= ST_IDLE;
            instr_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            illegal_q <= illegal_d;
        end
    end

    // Branch decision for the latched instruction using the current flags.
    always_comb begin
        taken = 1'b1;
        case (kind_q)
            K_CBZ:   taken = status[0];
            K_CBNZ:  taken = !status[0];
            K_BCOND: taken = cond_taken;
            default: taken = 1'b1;
        endcase
    end

    // Control word for the current state.
    always_comb begin
        // NOTE: default the whole word first so no path infers a latch.
        cw       = '0;
        cw.pc_fs = PC_HOLD;
        case (state_q)
            ST_EVAL: begin
                cw.alu_en      = 1'b0;
                cw.alu_fs      = ALU_PASS_A;
                cw.sel_a       = instr_q[4:0];
                cw.sel_b       = ZERO_REG;
                cw.status_load = 1'b1;
            end
            ST_LINK: begin
                cw.pc_en    = 1'b1;
                cw.rf_addr  = LINK_REG;
                cw.rf_write = 1'b1;
            end
            ST_BRANCH: begin
                if (kind_q == K_BR) begin
                    cw.rf_b_en   = 1'b1;
                    cw.sel_b     = instr_q[9:5];
                    cw.pc_fs     = PC_BUS;
                    cw.pc_in_sel = 1'b0;
                end else if (taken) begin
                    cw.pc_fs     = PC_REL;
                    cw.pc_in_sel = 1'b1;
                end else begin
                    cw.pc_fs     = PC_INC4;
                end
            end
            default: ;
        endcase
        cw.next_state = state_d;
    end

    // Sign-extended, word-scaled offset of the latched instruction.
    always_comb begin
        constant = '0;
        case (kind_q)
            K_CBZ, K_CBNZ, K_BCOND:
                constant = {{(DATA_WIDTH-21){instr_q[23]}}, instr_q[23:5], 2'b00};
            K_B, K_BL:
                constant = {{(DATA_WIDTH-28){instr_q[25]}}, instr_q[25:0], 2'b00};
            default: constant = '0;
        endcase
    end

    assign controlword  = cw;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_BRANCH);
    assign branch_taken = done && taken;
    assign illegal      = illegal_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench for branch_sequencer: the driver pushes the expected
// per-cycle responses of each instruction, a negedge monitor pops and
// compares them whenever the sequencer is busy or flags an illegal word.
module tb_branch_sequencer;

    localparam int DW = 64;

    // Instruction classes used by the reference model
    localparam int KN = 0, KCBZ = 1, KCBNZ = 2, KBC = 3, KB = 4, KBL = 5, KBR = 6;

    logic          clock = 1'b0;
    logic          reset;
    logic [31:0]   instruction;
    logic          instr_valid;
    logic [4:0]    status;
    logic [32:0]   controlword;
    logic [DW-1:0] constant;
    logic          busy, done, branch_taken, illegal;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [32:0] cw;
        logic [63:0] k;
        bit          chk_k;
        bit          done;
        bit          taken;
        bit          illegal;
    } exp_t;

    exp_t exp_q[$];

    branch_sequencer #(
        .DATA_WIDTH (DW),
        .LINK_REG   (5'd30),
        .ZERO_REG   (5'd31),
        .ENABLE_BL  (1'b1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .status       (status),
        .controlword  (controlword),
        .constant     (constant),
        .busy         (busy),
        .done         (done),
        .branch_taken (branch_taken),
        .illegal      (illegal)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int ref_kind(input logic [31:0] i);
        if (i[31:24] == 8'hB4) return KCBZ;
        if (i[31:24] == 8'hB5) return KCBNZ;
        if (i[31:24] == 8'h54 && i[4] == 1'b0) return KBC;
        if (i[31:26] == 6'b000101) return KB;
        if (i[31:26] == 6'b100101) return KBL;
        if (i[31:10] == 22'b1101011000011111000000) return KBR;
        return KN;
    endfunction

    function automatic logic [63:0] ref_const(input int kind, input logic [31:0] i);
        logic signed [18:0] s19;
        logic signed [25:0] s26;
        longint v;
        v = 0;
        if (kind == KCBZ || kind == KCBNZ || kind == KBC) begin
            s19 = i[23:5];
            v = longint'(s19) * 4;
        end else if (kind == KB || kind == KBL) begin
            s26 = i[25:0];
            v = longint'(s26) * 4;
        end
        return v;
    endfunction

    // ARM condition evaluation: base test from cond[3:1], inverted by cond[0]
    function automatic bit ref_cond(input logic [3:0] cond, input logic [4:0] st);
        bit z, n, c, v, r;
        z = st[0]; n = st[1]; c = st[2]; v = st[3];
        case (cond[3:1])
            3'd0: r = z;
            3'd1: r = c;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = c && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (cond[0] && cond != 4'hF) r = !r;
        return r;
    endfunction

    function automatic bit ref_taken(input int kind, input logic [31:0] i, input logic [4:0] st);
        if (kind == KCBZ)  return st[0];
        if (kind == KCBNZ) return !st[0];
        if (kind == KBC)   return ref_cond(i[3:0], st);
        return 1'b1;
    endfunction

    // Control word with alu_en, alu_b_sel, ram_en, ram_write always 0
    function automatic logic [32:0] mk_cw(input logic [4:0] alu_fs, input logic rf_b_en,
                                          input logic [4:0] sel_a, input logic [4:0] sel_b,
                                          input logic [4:0] rf_addr, input logic rf_write,
                                          input logic pc_en, input logic [1:0] pc_fs,
                                          input logic pc_in_sel, input logic status_load,
                                          input logic [1:0] ns);
        return {1'b0, 1'b0, alu_fs, rf_b_en, sel_a, sel_b, rf_addr, rf_write,
                1'b0, 1'b0, pc_en, pc_fs, pc_in_sel, status_load, ns};
    endfunction

    // Push the expected busy-cycle responses of one instruction; returns latency.
    function automatic int push_expect(input logic [31:0] i, input logic [4:0] st);
        int   kind;
        exp_t e;
        bit   t;
        kind = ref_kind(i);
        e.k = ref_const(kind, i);
        e.chk_k = 1'b1;
        e.illegal = 1'b0;
        if (kind == KN) begin
            e.tag = "illegal"; e.cw = '0; e.chk_k = 1'b0;
            e.done = 1'b0; e.taken = 1'b0; e.illegal = 1'b1;
            exp_q.push_back(e);
            return 0;
        end
        if (kind == KCBZ || kind == KCBNZ) begin
            e.tag = "eval"; e.done = 1'b0; e.taken = 1'b0;
            e.cw = mk_cw(5'b00100, 0, i[4:0], 5'd31, 5'd0, 0, 0, 2'b00, 0, 1, 2'b10);
            exp_q.push_back(e);
        end
        if (kind == KBL) begin
            e.tag = "link"; e.done = 1'b0; e.taken = 1'b0;
            e.cw = mk_cw(5'd0, 0, 5'd0, 5'd0, 5'd30, 1, 1, 2'b00, 0, 0, 2'b10);
            exp_q.push_back(e);
        end
        t = ref_taken(kind, i, st);
        e.tag = "branch"; e.done = 1'b1; e.taken = t;
        if (kind == KBR)
            e.cw = mk_cw(5'd0, 1, 5'd0, i[9:5], 5'd0, 0, 0, 2'b11, 0, 0, 2'b00);
        else if (t)
            e.cw = mk_cw(5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 2'b10, 1, 0, 2'b00);
        else
            e.cw = mk_cw(5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 2'b01, 0, 0, 2'b00);
        exp_q.push_back(e);
        return (kind == KCBZ || kind == KCBNZ || kind == KBL) ? 2 : 1;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        if (!reset) begin
            if (busy || illegal) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: busy=%b illegal=%b cw=%h with nothing expected",
                             busy, illegal, controlword);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check({e.tag, ".cw"}, 64'(controlword), 64'(e.cw));
                    if (e.chk_k) check({e.tag, ".constant"}, constant, e.k);
                    check({e.tag, ".done"}, 64'(done), 64'(e.done));
                    if (e.done) check({e.tag, ".taken"}, 64'(branch_taken), 64'(e.taken));
                    check({e.tag, ".illegal"}, 64'(illegal), 64'(e.illegal));
                    check({e.tag, ".busy"}, 64'(busy), 64'(!e.illegal));
                end
            end else begin
                check("idle.done", 64'(done), 64'd0);
            end
        end
    end

    // ---------------- driver ----------------
    // Present one instruction for one cycle (or hold valid with busy_word
    // during the busy cycles) and wait until the sequencer is idle again.
    task automatic send(input logic [31:0] i, input logic [4:0] st,
                        input bit hold, input logic [31:0] busy_word);
        int lat;
        instruction = i;
        status      = st;
        instr_valid = 1'b1;
        lat = push_expect(i, st);
        @(posedge clock); #1;
        if (hold) instruction = busy_word;
        else      instr_valid = 1'b0;
        if (lat == 0) begin
            instr_valid = 1'b0;
            @(posedge clock); #1;
        end else begin
            repeat (lat) begin
                @(posedge clock); #1;
            end
        end
        instr_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [31:0] w;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: w = {8'hB4, r[23:5], r[4:0]};
            1: w = {8'hB5, r[23:5], r[4:0]};
            2: w = {8'h54, r[23:5], 1'b0, r[3:0]};
            3: w = {6'b000101, r[25:0]};
            4: w = {6'b100101, r[25:0]};
            5: w = {22'b1101011000011111000000, r[9:5], 5'd0};
            6: w = {8'h54, r[23:5], 1'b1, r[3:0]};
            default: w = r;
        endcase
        return w;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b0;
        instruction = '0;
        status      = '0;
        repeat (3) @(posedge clock);
        #3;
        check("reset.cw", 64'(controlword), 64'd0);
        check("reset.constant", constant, 64'd0);
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.taken", 64'(branch_taken), 64'd0);
        check("reset.illegal", 64'(illegal), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // CBZ X3, +4 with Z=1: taken, constant 16
        send({8'hB4, 19'd4, 5'd3}, 5'b00001, 0, '0);
        // CBNZ with Z=1: not taken
        send({8'hB5, 19'd4, 5'd7}, 5'b00001, 0, '0);
        // Negative offset: imm19 all ones -> -4
        send({8'hB4, 19'h7FFFF, 5'd1}, 5'b00000, 0, '0);
        // BL with imm26 all ones
        send({6'b100101, 26'h3FFFFFF}, 5'b00000, 0, '0);
        // B.cond GT and LT with N=1, V=1, Z=0
        send({8'h54, 19'd8, 1'b0, 4'hC}, 5'b01010, 0, '0);
        send({8'h54, 19'd8, 1'b0, 4'hB}, 5'b01010, 0, '0);
        // BR X9 and plain B
        send({22'b1101011000011111000000, 5'd9, 5'd0}, 5'b00000, 0, '0);
        send({6'b000101, 26'h0000123}, 5'b00000, 0, '0);
        // Unrecognised words: all ones, and B.cond with bit 4 set
        send(32'hFFFF_FFFF, 5'b00000, 0, '0);
        send({8'h54, 19'd3, 1'b1, 4'h0}, 5'b00000, 0, '0);
        // instr_valid held while busy with other words is ignored
        send({8'hB4, 19'd2, 5'd5}, 5'b00000, 1, {6'b000101, 26'h0000040});
        send({6'b100101, 26'h0000010}, 5'b00000, 1, 32'h0000_0000);

        // Reset while in EVAL: back to IDLE with no done pulse
        instruction = {8'hB4, 19'd6, 5'd2};
        status      = 5'b00001;
        instr_valid = 1'b1;
        begin
            exp_t e;
            e.tag = "abort_eval"; e.k = 64'd24; e.chk_k = 1'b1;
            e.done = 1'b0; e.taken = 1'b0; e.illegal = 1'b0;
            e.cw = mk_cw(5'b00100, 0, 5'd2, 5'd31, 5'd0, 0, 0, 2'b00, 0, 1, 2'b10);
            exp_q.push_back(e);
        end
        @(posedge clock); #1;
        instr_valid = 1'b0;
        @(negedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #3;
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.done", 64'(done), 64'd0);
        check("abort.cw", 64'(controlword), 64'd0);
        check("abort.constant", constant, 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        send({8'hB5, 19'h7FFF0, 5'd4}, 5'b00000, 0, '0);

        // Randomized traffic, random flags including the reserved bit
        for (int n = 0; n < 300; n++) begin
            logic [4:0] st;
            st = 5'($urandom_range(0, 31));
            send(rand_instr(), st, ($urandom_range(0, 3) == 0), $urandom);
        end

        repeat (3) @(posedge clock);
        #1;
        check("scoreboard.empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Multi-cycle, parametrised branch control sequencer for the single-cycle-datapath control unit.
- Owns its own state register and latches the accepted instruction.
- Handles CBZ, CBNZ, B, BL, B.cond and BR.
- Emits one datapath control word per cycle in the standard control-word field order, plus the sign-extended, word-scaled branch offset, and reports completion and whether the branch was taken.

Parameters:
- DATA_WIDTH, 64, width of `constant` and datapath.
- LINK_REG, 30, register written by BL.
- ZERO_REG, 31, register index for the unused select B.
- ENABLE_BL, 1, when 0, BL decodes as illegal.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- instruction  in  32  instruction word, sampled when accepted
- instr_valid  in  1  instruction present; ignored while busy
- status  in  5  [0]=Z [1]=N [2]=C [3]=V registered flags; [4] reserved/ignored
- controlword  out  33  {alu_en, alu_b_sel, alu_fs[4:0], rf_b_en, sel_a[4:0], sel_b[4:0], rf_addr[4:0], rf_write, ram_en, ram_write, pc_en, pc_fs[1:0], pc_in_sel, status_load, next_state[1:0]}
- constant  out  DATA_WIDTH  sign-extended offset <<2 from the latched instruction
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse in the final BRANCH cycle
- branch_taken  out  1  valid only when done=1
- illegal  out  1  one-cycle pulse when a valid instruction is not recognised

Behaviour:
- Reset:
  - state=IDLE, instr_q=0, illegal=0.
  - controlword is all-zero, so `next_state` reads 00.
  - constant=0, busy=0, done=0, branch_taken=0.
  - Reset mid-operation aborts the sequence with no done pulse.
- Encoding:
  - States: IDLE=00, EVAL=01, BRANCH=10, LINK=11.
  - pc_fs: 00 hold, 01 PC+4, 10 PC+constant (pc_in_sel=1), 11 load from databus (pc_in_sel=0).
  - `pc_en` drives PC+4 (the return address) onto the databus.
- Decode (instr[31:24], or wider where listed):
  - CBZ: 10110100.
  - CBNZ: 10110101.
  - B.cond: 01010100 with [4]=0.
  - B: [31:26]=000101.
  - BL: [31:26]=100101.
  - BR: [31:10]=1101011000011111000000.
- Immediates:
  - imm19 = instr[23:5] for CBZ, CBNZ and B.cond.
  - imm26 = instr[25:0] for B and BL.
  - constant is sign-extended to DATA_WIDTH then <<2.
- IDLE:
  - controlword is all-zero.
  - On instr_valid, latch the instruction and move to:
    - EVAL for CBZ/CBNZ;
    - LINK for BL;
    - BRANCH for B, B.cond and BR.
  - Unrecognised instruction: pulse illegal, stay in IDLE.
- EVAL (CBZ/CBNZ):
  - alu_en=0, alu_fs=00100 (pass A), sel_a=Rt[4:0], sel_b=ZERO_REG, status_load=1.
  - next_state=BRANCH.
  - Z is registered at the end of this cycle.
- LINK (BL):
  - pc_en=1, rf_addr=LINK_REG, rf_write=1.
  - next_state=BRANCH.
- BRANCH:
  - Taken conditions:
    - CBZ: Z=1.
    - CBNZ: Z=0.
    - B, BL and BR: always.
    - B.cond on cond=instr[3:0], ARM semantics: EQ, NE, CS, CC, MI, PL, VS, VC, HI (C&!Z), LS, GE (N==V), LT, GT (!Z&N==V), LE, AL; NV is treated as always.
  - Taken: pc_fs=10, pc_in_sel=1.
  - BR: sel_b=Rn=instr[9:5], rf_b_en=1, pc_fs=11, pc_in_sel=0.
  - Not taken: pc_fs=01.
  - done=1, branch_taken set accordingly, next_state=IDLE.
- Latency (accept to done):
  - B, B.cond, BR: 1 cycle.
  - CBZ, CBNZ, BL: 2 cycles.
  - A new instruction is accepted in the cycle after done.
- Timing:
  - controlword, constant and the flags are combinational from state_q, instr_q and status.
  - The field `next_state` always equals the registered next state.

Decomposition:
- Package `branch_pkg`: state encodings, pc_fs codes, opcode constants, ALU_PASS_A=00100, CW_WIDTH=33, cond-code constants.
- One natural sub-module, `cond_evaluator`: combinational, takes cond[3:0] and {V,C,N,Z}, returns taken.

Test Plan:
- **CBZ taken:** reset, then CBZ X3, imm19=+4 with status Z=1 at BRANCH.
  - EVAL controlword has sel_a=3 and status_load=1.
  - BRANCH has pc_fs=10 and constant=16; done=1, branch_taken=1 at cycle 2.
- **CBNZ not taken:** CBNZ with Z=1 → BRANCH pc_fs=01, branch_taken=0.
- **Negative offset:** imm19 = all-ones → constant = 0xFFFF_FFFF_FFFF_FFFC.
- **BL:** BL with imm26=0x3FFFFFF.
  - LINK has rf_addr=30, rf_write=1, pc_en=1.
  - BRANCH has constant=-4 and pc_fs=10.
- **B.cond:** GT with N=1, V=1, Z=0 → taken; LT with the same flags → not taken; done after 1 cycle each.
- **Control and abort:**
  - Unrecognised opcode → illegal pulse, busy stays 0.
  - instr_valid held while busy → ignored.
  - reset in EVAL → IDLE next cycle, no done.
